// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan_decoder block: FSM state encodings and
// mode-select constants.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage : scan_decoder_pkg

// File: rtl/onehot_decoder.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with enable.
// With en low every output line is zero.
module onehot_decoder #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic                  en,
    output logic [2**SEL_W-1:0]   onehot
);

    localparam int OUT_W = 2**SEL_W;

    // One comparator per output line, so at most one line can ever be high.
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_line
            assign onehot[gi] = en && (sel == SEL_W'(gi));
        end
    endgenerate

endmodule : onehot_decoder

// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2**N one-hot decoder with an auto-scan mode.
//   DECODE: Out/Index follow A with one cycle of latency.
//   SCAN  : starts at A, advances one line every DWELL cycles and pulses
//           Wrap for one cycle each time the index rolls over to 0.
// Optional build macro SCAN_DECODER_ACTIVE_LOW_EN inverts the Out port
// (idle = all ones, active line = 0); Index and Wrap are unaffected.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEL_W-1:0]      A,
    input  logic                  E,
    input  logic                  Mode,
    output logic [2**SEL_W-1:0]   Out,
    output logic [SEL_W-1:0]      Index,
    output logic                  Wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] INDEX_LAST = SEL_W'(OUT_W - 1);

    state_t              state_reg, state_next;
    logic [SEL_W-1:0]    index_reg, index_next;
    logic [DW_W-1:0]     dwell_reg, dwell_next;
    logic                wrap_reg, wrap_next;
    logic [OUT_W-1:0]    out_reg, onehot_next;
    logic                out_en_next;

    // Next-state decision for the FSM, index, dwell counter and wrap flag.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        dwell_next = dwell_reg;
        wrap_next  = 1'b0;
        if (!E) begin
            state_next = ST_IDLE;
            index_next = '0;
            dwell_next = '0;
        end else if (Mode == MODE_DECODE) begin
            state_next = ST_DECODE;
            index_next = A;
            dwell_next = '0;
        end else if (state_reg != ST_SCAN) begin
            // Fresh scan entry: start line comes from A, full dwell ahead.
            state_next = ST_SCAN;
            index_next = A;
            dwell_next = '0;
        end else if (dwell_reg == DWELL_LAST) begin
            // Natural SEL_W-bit overflow provides the wrap to line 0.
            state_next = ST_SCAN;
            index_next = index_reg + SEL_W'(1);
            dwell_next = '0;
            wrap_next  = (index_reg == INDEX_LAST);
        end else begin
            state_next = ST_SCAN;
            dwell_next = dwell_reg + DW_W'(1);
        end
    end

    assign out_en_next = (state_next != ST_IDLE);

    onehot_decoder #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .sel    (index_next),
        .en     (out_en_next),
        .onehot (onehot_next)
    );

    // State, index, dwell, wrap and one-hot output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            index_reg <= '0;
            dwell_reg <= '0;
            wrap_reg  <= 1'b0;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            dwell_reg <= dwell_next;
            wrap_reg  <= wrap_next;
            out_reg   <= onehot_next;
        end
    end

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    assign Out = ~out_reg;
`else
    assign Out = out_reg;
`endif
    assign Index = index_reg;
    assign Wrap  = wrap_reg;

endmodule : scan_decoder

// File: tb/tb_scan_decoder.sv
// Testbench for scan_decoder: two instances (DWELL=4 and DWELL=1) share the
// stimulus; a sweep-level model (start line plus elapsed scan cycles) gives
// the expected outputs every cycle, and directed steps pin literal values.
module tb_scan_decoder;

    localparam int OW = 8;
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    localparam logic [7:0] INV = 8'hFF;
`else
    localparam logic [7:0] INV = 8'h00;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       E     = 1'b0;
    logic       Mode  = 1'b0;
    logic [2:0] A     = 3'd0;

    logic [7:0] out0, out1;
    logic [2:0] idx0, idx1;
    logic       wrap0, wrap1;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .DWELL(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .A(A), .E(E), .Mode(Mode),
        .Out(out0), .Index(idx0), .Wrap(wrap0)
    );

    scan_decoder #(.SEL_W(3), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(A), .E(E), .Mode(Mode),
        .Out(out1), .Index(idx1), .Wrap(wrap1)
    );

    // Behavioural model: per instance, whether a line is active, whether it
    // is scanning, the start line and how many edges have passed in SCAN.
    int dw [2] = '{4, 1};
    bit m_act  [2];
    bit m_scan [2];
    int m_start[2];
    int m_cnt  [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || !E) begin
                m_act[i] = 0; m_scan[i] = 0; m_start[i] = 0; m_cnt[i] = 0;
            end else if (Mode == 1'b0) begin
                m_act[i] = 1; m_scan[i] = 0; m_start[i] = int'(A); m_cnt[i] = 0;
            end else if (!m_scan[i]) begin
                m_act[i] = 1; m_scan[i] = 1; m_start[i] = int'(A); m_cnt[i] = 0;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
    end

    function automatic int exp_idx(int i);
        if (m_scan[i]) return (m_start[i] + m_cnt[i] / dw[i]) % OW;
        return m_start[i];
    endfunction

    function automatic int exp_out(int i);
        if (!m_act[i]) return 0;
        return 1 << exp_idx(i);
    endfunction

    function automatic int exp_wrap(int i);
        return (m_scan[i] && m_cnt[i] > 0 && (m_cnt[i] % dw[i]) == 0 &&
                exp_idx(i) == 0) ? 1 : 0;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model for both instances.
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            check("m_out0",  int'(out0 ^ INV), exp_out(0));
            check("m_idx0",  int'(idx0),       exp_idx(0));
            check("m_wrap0", int'(wrap0),      exp_wrap(0));
            check("m_out1",  int'(out1 ^ INV), exp_out(1));
            check("m_idx1",  int'(idx1),       exp_idx(1));
            check("m_wrap1", int'(wrap1),      exp_wrap(1));
            check("onehot0", ($countones(out0 ^ INV) <= 1) ? 1 : 0, 1);
            check("onehot1", ($countones(out1 ^ INV) <= 1) ? 1 : 0, 1);
        end
    end

    // Asynchronous reset pulse taken mid-cycle, checked before any edge.
    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out0",  int'(out0 ^ INV), 0);
        check("rst_idx0",  int'(idx0), 0);
        check("rst_wrap0", int'(wrap0), 0);
        check("rst_out1",  int'(out1 ^ INV), 0);
        $display("txn reset out0=%02h idx0=%0d wrap0=%0d", out0, idx0, wrap0);
        @(negedge clk);
        E = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int wrap_dist;
        int found;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
        E = 1'b1; Mode = 1'b1; A = 3'd3;
        repeat (3) @(negedge clk);

        // Test 1: asynchronous reset mid-scan
        async_reset();

        // Test 2: DECODE sweep, then disable
        for (int a = 0; a < OW; a++) begin
            @(negedge clk);
            E = 1'b1; Mode = 1'b0; A = 3'(a);
            @(negedge clk);
            check("dec_out", int'(out0 ^ INV), 1 << a);
            check("dec_idx", int'(idx0), a);
            $display("txn decode A=%0d out=%02h idx=%0d", a, out0, idx0);
        end
        E = 1'b0;
        @(negedge clk);
        check("idle_out", int'(out0 ^ INV), 0);
        check("idle_idx", int'(idx0), 0);
        $display("txn idle out=%02h", out0);

        // Test 3: SCAN from line 6 with DWELL=4
        E = 1'b1; Mode = 1'b1; A = 3'd6;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            A = 3'($urandom);
            if (k < 4)       check("scan_out", int'(out0 ^ INV), 8'h40);
            else if (k < 8)  check("scan_out", int'(out0 ^ INV), 8'h80);
            else             check("scan_out", int'(out0 ^ INV), 8'h01);
            check("scan_wrap", int'(wrap0), (k == 8) ? 1 : 0);
            $display("txn scan k=%0d out=%02h wrap=%0d", k, out0, wrap0);
        end
        wrap_dist = 1; found = 0;
        while (!found && wrap_dist < 40) begin
            @(negedge clk);
            wrap_dist++;
            if (wrap0) found = 1;
        end
        check("wrap_period", found ? wrap_dist : -1, 32);
        $display("txn wrap_period=%0d", wrap_dist);

        // Test 4: leave SCAN at Index=2, dwell=1, then re-enter
        repeat (9) @(negedge clk);
        check("sw_idx_before", int'(idx0), 2);
        Mode = 1'b0; A = 3'd5;
        @(negedge clk);
        check("sw_out", int'(out0 ^ INV), 8'h20);
        check("sw_wrap", int'(wrap0), 0);
        Mode = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("sw_scan_idx", int'(idx0), (k < 4) ? 5 : 6);
        end
        $display("txn mode_switch idx=%0d", idx0);

        // Test 5: DWELL=1 instance walks one line per cycle from 0
        E = 1'b0;
        @(negedge clk);
        E = 1'b1; Mode = 1'b1; A = 3'd0;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            check("d1_out",  int'(out1 ^ INV), 1 << (k % OW));
            check("d1_wrap", int'(wrap1), (k > 0 && (k % OW) == 0) ? 1 : 0);
        end
        $display("txn dwell1 out=%02h wrap=%0d", out1, wrap1);

        // Random phase with occasional mid-cycle resets
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            E = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 9) == 0) Mode = ~Mode;
            A = 3'($urandom);
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_scan_decoder
